// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
// Define STREAM_FIFO_PEAK_EN to add the peak_o high-water-mark output.
module stream_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [Width-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [Width-1:0]           data_o,
`ifdef STREAM_FIFO_PEAK_EN
  output logic [$clog2(Depth+1)-1:0] peak_o,
`endif
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign ready_o = (count_q != DepthCnt);
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !clear_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

`ifdef STREAM_FIFO_PEAK_EN
  logic [CntW-1:0] peak_q, peak_d;

  // Tracks the next count so the mark moves in the same cycle as count_o.
  always_comb begin
    peak_d = peak_q;
    if (clear_i) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (Width 8, Depth 4).
module tb_stream_fifo;

  logic       clk;
  logic       rst_ni;
  logic       clear_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic [2:0] count_o;
`ifdef STREAM_FIFO_PEAK_EN
  logic [2:0] peak_o;
`endif

  int tests;
  int fails;

  stream_fifo #(
    .Width(8),
    .Depth(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
`ifdef STREAM_FIFO_PEAK_EN
    .peak_o (peak_o),
`endif
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_exp [4];
    logic [7:0] full_exp [3];
    fill_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    full_exp = '{8'hB2, 8'hB3, 8'hB4};
    tests   = 0;
    fails   = 0;
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;

    #3;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_data", 32'(data_o), 32'h00);
    tick();
    rst_ni = 1'b1;

    // Fill with the output stalled.
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = fill_exp[i];
      tick();
      check("fill_count", 32'(count_o), 32'(i + 1));
    end
    check("full_ready", 32'(ready_o), 32'd0);
    check("full_valid", 32'(valid_o), 32'd1);
    data_i = 8'h55;
    tick();
    check("refused_count", 32'(count_o), 32'd4);
    check("refused_ready", 32'(ready_o), 32'd0);
`ifdef STREAM_FIFO_PEAK_EN
    check("peak_full", 32'(peak_o), 32'd4);
`endif

    // Drain in order.
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(valid_o), 32'd1);
      check("drain_data", 32'(data_o), 32'(fill_exp[i]));
      tick();
    end
    check("drained_valid", 32'(valid_o), 32'd0);
    check("drained_count", 32'(count_o), 32'd0);

    // Simultaneous push and pop at level 2.
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h01;
    tick();
    data_i  = 8'h02;
    tick();
    check("lvl2_count", 32'(count_o), 32'd2);
    data_i  = 8'hA5;
    ready_i = 1'b1;
    tick();
    check("pushpop_count", 32'(count_o), 32'd2);
    check("pushpop_data", 32'(data_o), 32'h02);
    valid_i = 1'b0;
    tick();
    check("pushpop_next", 32'(data_o), 32'hA5);
    tick();
    check("pushpop_empty", 32'(valid_o), 32'd0);

    // Full with both sides active: pop only.
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'hB1 + 8'(i);
      tick();
    end
    check("full2_count", 32'(count_o), 32'd4);
    data_i  = 8'hC5;
    ready_i = 1'b1;
    tick();
    check("fullpop_count", 32'(count_o), 32'd3);
    check("fullpop_ready", 32'(ready_o), 32'd1);
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("fullpop_data", 32'(data_o), 32'(full_exp[i]));
      tick();
    end
    check("fullpop_empty", 32'(valid_o), 32'd0);

    // Streaming across several pointer wraps.
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      data_i = 8'(i);
      tick();
      check("wrap_valid", 32'(valid_o), 32'd1);
      check("wrap_data", 32'(data_o), 32'(i));
      check("wrap_count", 32'(count_o), 32'd1);
    end
    valid_i = 1'b0;
    tick();
    check("wrap_empty", 32'(valid_o), 32'd0);

    // Flush at level 3 with push and pop requested.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = 8'hD1 + 8'(i);
      tick();
    end
    check("preflush_count", 32'(count_o), 32'd3);
`ifdef STREAM_FIFO_PEAK_EN
    check("preflush_peak", 32'(peak_o), 32'd3);
`endif
    clear_i = 1'b1;
    ready_i = 1'b1;
    data_i  = 8'hEE;
    tick();
    clear_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_ready", 32'(ready_o), 32'd1);
`ifdef STREAM_FIFO_PEAK_EN
    check("flush_peak", 32'(peak_o), 32'd0);
`endif
    tick();
    check("flush_hold", 32'(count_o), 32'd0);

    // Asynchronous reset mid-burst.
    valid_i = 1'b1;
    data_i  = 8'h71;
    tick();
    data_i  = 8'h72;
    tick();
    check("preRst_count", 32'(count_o), 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_valid", 32'(valid_o), 32'd0);
    check("async_count", 32'(count_o), 32'd0);
    check("async_ready", 32'(ready_o), 32'd1);
    check("async_data", 32'(data_o), 32'h00);
    valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    check("postRst_valid", 32'(valid_o), 32'd0);
    valid_i = 1'b1;
    data_i  = 8'hE7;
    tick();
    valid_i = 1'b0;
    check("postRst_data", 32'(data_o), 32'hE7);
    check("postRst_count", 32'(count_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
